// File: rtl/uart_ahb_pkg.sv
// Shared encodings, register map and FSM states for the UART AHB-Lite initiator.
package uart_ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [2:0] HSIZE_WORD    = 3'b010;

  localparam logic [7:0] DATA_OFS = 8'h00;
  localparam logic [7:0] STAT_OFS = 8'h04;

  localparam int unsigned TXFULL_BIT  = 1;
  localparam int unsigned RXEMPTY_BIT = 0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_S_ADDR,
    ST_S_DATA,
    ST_X_ADDR,
    ST_X_DATA,
    ST_RESP
  } state_t;

endpackage

// File: rtl/uart_ahb_master_if.sv
// Command/response handshake plus AHB-Lite initiator signals of the UART master.
interface uart_ahb_master_if;

  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [7:0]  cmd_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [7:0]  rsp_rdata;
  logic        rsp_err;
  logic [1:0]  HTRANS;
  logic [31:0] HADDR;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [31:0] HWDATA;
  logic [31:0] HRDATA;
  logic        HREADY;

  modport master (
    input  cmd_valid, cmd_write, cmd_wdata, rsp_ready, HRDATA, HREADY,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err,
    output HTRANS, HADDR, HWRITE, HSIZE, HWDATA
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_wdata, rsp_ready, HRDATA, HREADY,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err,
    input  HTRANS, HADDR, HWRITE, HSIZE, HWDATA
  );

endinterface

// File: rtl/uart_ahb_master.sv
// Byte command to AHB-Lite bridge: polls UART status, then does one data-register transfer.
module uart_ahb_master
  import uart_ahb_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned POLL_MAX  = 1024,
  parameter int unsigned POLL_W    = 11
) (
  input  logic              HCLK,
  input  logic              HRESET,
  uart_ahb_master_if.master bus
);

  localparam logic [31:0] STAT_ADDR = BASE_ADDR + 32'(STAT_OFS);
  localparam logic [31:0] DATA_ADDR = BASE_ADDR + 32'(DATA_OFS);

  state_t              r_state,       w_state_nxt;
  logic                r_cmd_write,   w_cmd_write_nxt;
  logic [7:0]          r_cmd_wdata,   w_cmd_wdata_nxt;
  logic [POLL_W-1:0]   r_poll_cnt,    w_poll_cnt_nxt;
  logic [1:0]          r_htrans,      w_htrans_nxt;
  logic [31:0]         r_haddr,       w_haddr_nxt;
  logic                r_hwrite,      w_hwrite_nxt;
  logic [31:0]         r_hwdata,      w_hwdata_nxt;
  logic                r_rsp_valid,   w_rsp_valid_nxt;
  logic [7:0]          r_rsp_rdata,   w_rsp_rdata_nxt;
  logic                r_rsp_err,     w_rsp_err_nxt;
  logic                w_stat_ok;

  // State and registered bus/response outputs
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      r_state     <= ST_IDLE;
      r_cmd_write <= 1'b0;
      r_cmd_wdata <= 8'h00;
      r_poll_cnt  <= '0;
      r_htrans    <= HTRANS_IDLE;
      r_haddr     <= 32'h0;
      r_hwrite    <= 1'b0;
      r_hwdata    <= 32'h0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= 8'h00;
      r_rsp_err   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cmd_write <= w_cmd_write_nxt;
      r_cmd_wdata <= w_cmd_wdata_nxt;
      r_poll_cnt  <= w_poll_cnt_nxt;
      r_htrans    <= w_htrans_nxt;
      r_haddr     <= w_haddr_nxt;
      r_hwrite    <= w_hwrite_nxt;
      r_hwdata    <= w_hwdata_nxt;
      r_rsp_valid <= w_rsp_valid_nxt;
      r_rsp_rdata <= w_rsp_rdata_nxt;
      r_rsp_err   <= w_rsp_err_nxt;
    end
  end

  // Next state; address-phase outputs are computed from the state being entered
  always_comb begin
    w_state_nxt     = r_state;
    w_cmd_write_nxt = r_cmd_write;
    w_cmd_wdata_nxt = r_cmd_wdata;
    w_poll_cnt_nxt  = r_poll_cnt;
    w_htrans_nxt    = r_htrans;
    w_haddr_nxt     = r_haddr;
    w_hwrite_nxt    = r_hwrite;
    w_hwdata_nxt    = r_hwdata;
    w_rsp_valid_nxt = r_rsp_valid;
    w_rsp_rdata_nxt = r_rsp_rdata;
    w_rsp_err_nxt   = r_rsp_err;
    w_stat_ok       = r_cmd_write ? ~bus.HRDATA[TXFULL_BIT] : ~bus.HRDATA[RXEMPTY_BIT];

    unique case (r_state)
      ST_IDLE: begin
        if (bus.cmd_valid) begin
          w_state_nxt     = ST_S_ADDR;
          w_cmd_write_nxt = bus.cmd_write;
          w_cmd_wdata_nxt = bus.cmd_wdata;
          w_htrans_nxt    = HTRANS_NONSEQ;
          w_haddr_nxt     = STAT_ADDR;
          w_hwrite_nxt    = 1'b0;
        end
      end
      ST_S_ADDR: begin
        w_state_nxt    = ST_S_DATA;
        w_poll_cnt_nxt = r_poll_cnt + POLL_W'(1);
        w_htrans_nxt   = HTRANS_IDLE;
      end
      ST_S_DATA: begin
        if (bus.HREADY) begin
          if (w_stat_ok) begin
            w_state_nxt  = ST_X_ADDR;
            w_htrans_nxt = HTRANS_NONSEQ;
            w_haddr_nxt  = DATA_ADDR;
            w_hwrite_nxt = r_cmd_write;
          end else if (r_poll_cnt < POLL_W'(POLL_MAX)) begin
            w_state_nxt  = ST_S_ADDR;
            w_htrans_nxt = HTRANS_NONSEQ;
            w_haddr_nxt  = STAT_ADDR;
            w_hwrite_nxt = 1'b0;
          end else begin
            w_state_nxt     = ST_RESP;
            w_rsp_valid_nxt = 1'b1;
            w_rsp_err_nxt   = 1'b1;
            w_rsp_rdata_nxt = 8'h00;
          end
        end
      end
      ST_X_ADDR: begin
        w_state_nxt  = ST_X_DATA;
        w_htrans_nxt = HTRANS_IDLE;
        w_hwdata_nxt = r_cmd_write ? {24'h0, r_cmd_wdata} : 32'h0;
      end
      ST_X_DATA: begin
        if (bus.HREADY) begin
          w_state_nxt     = ST_RESP;
          w_rsp_valid_nxt = 1'b1;
          w_rsp_err_nxt   = 1'b0;
          w_rsp_rdata_nxt = r_cmd_write ? 8'h00 : bus.HRDATA[7:0];
        end
      end
      ST_RESP: begin
        if (bus.rsp_ready) begin
          w_state_nxt     = ST_IDLE;
          w_rsp_valid_nxt = 1'b0;
          w_poll_cnt_nxt  = '0;
          w_hwdata_nxt    = 32'h0;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign bus.cmd_ready = (r_state == ST_IDLE);
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_rdata = r_rsp_rdata;
  assign bus.rsp_err   = r_rsp_err;
  assign bus.HTRANS    = r_htrans;
  assign bus.HADDR     = r_haddr;
  assign bus.HWRITE    = r_hwrite;
  assign bus.HSIZE     = HSIZE_WORD;
  assign bus.HWDATA    = r_hwdata;

endmodule

// File: tb/tb_uart_ahb_master.sv
// Bench for uart_ahb_master: AHB slave model, table vectors, random commands, corner sequences.
module tb_uart_ahb_master;
  import uart_ahb_pkg::*;

  localparam logic [31:0] BASE = 32'h4000_1000;
  localparam int unsigned PMAX = 4;

  logic HCLK = 1'b0;
  logic HRESET;
  always #5 HCLK = ~HCLK;

  uart_ahb_master_if bus ();

  uart_ahb_master #(.BASE_ADDR(BASE), .POLL_MAX(PMAX), .POLL_W(3)) dut (
    .HCLK  (HCLK),
    .HRESET(HRESET),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  // Slave-side state shared with the command tasks
  logic [31:0] stat_q[$];
  logic [31:0] rd_val;
  int          slv_wait;
  logic [31:0] exp_wdata;
  int          n_stat, n_data;
  logic        d_write;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] next_stat();
    logic [31:0] v;
    if (stat_q.size() == 0) return 32'h0;
    if (stat_q.size() == 1) return stat_q[0];
    v = stat_q.pop_front();
    return v;
  endfunction

  // AHB-Lite slave: one data phase after each NONSEQ, slv_wait stall cycles each
  initial begin : slave
    logic        dp_active, dp_wr, dp_first, hr, addr_seen, a_wr;
    logic [31:0] dp_addr, dp_haddr0, a_addr;
    int          dp_left;
    dp_active = 1'b0; dp_wr = 1'b0; dp_first = 1'b0; dp_left = 0;
    dp_addr = 32'h0; dp_haddr0 = 32'h0; a_addr = 32'h0; a_wr = 1'b0;
    bus.HREADY = 1'b1;
    bus.HRDATA = 32'h0;
    forever begin
      @(negedge HCLK);
      hr = 1'b1;
      if (dp_active) begin
        chk("htrans_in_dphase", 32'(bus.HTRANS), 32'(HTRANS_IDLE));
        if (dp_first) dp_haddr0 = bus.HADDR;
        else chk("haddr_stable", bus.HADDR, dp_haddr0);
        dp_first = 1'b0;
        if (dp_addr == BASE) chk("hwdata_dphase", bus.HWDATA, exp_wdata);
        if (dp_left > 0) begin
          hr = 1'b0;
          dp_left--;
          bus.HRDATA = $urandom;
        end else if (dp_addr == BASE + 32'h4) begin
          bus.HRDATA = next_stat();
        end else begin
          bus.HRDATA = rd_val;
        end
      end else begin
        bus.HRDATA = $urandom;
      end
      bus.HREADY = hr;
      addr_seen = (bus.HTRANS === HTRANS_NONSEQ);
      if (addr_seen) begin
        chk("hsize", 32'(bus.HSIZE), 32'(HSIZE_WORD));
        a_addr = bus.HADDR;
        a_wr   = bus.HWRITE;
      end
      @(posedge HCLK);
      if (HRESET) begin
        dp_active = 1'b0;
      end else begin
        if (dp_active && hr) begin
          dp_active = 1'b0;
          if (dp_addr == BASE + 32'h4) begin
            n_stat++;
            chk("stat_hwrite", 32'(dp_wr), 32'h0);
          end else if (dp_addr == BASE) begin
            n_data++;
            d_write = dp_wr;
          end else begin
            chk("haddr_legal", dp_addr, BASE);
          end
        end
        if (addr_seen) begin
          dp_active = 1'b1;
          dp_first  = 1'b1;
          dp_addr   = a_addr;
          dp_wr     = a_wr;
          dp_left   = slv_wait;
        end
      end
    end
  end

  // Issue one command (caller is negedge-aligned); check latency, response, traffic, handshake
  task automatic run_cmd(input string nm, input logic wr, input logic [7:0] b,
                         input int hold, input bit b2b, input logic nwr, input logic [7:0] nb,
                         input logic exp_err, input int exp_polls, input logic [7:0] exp_rdata,
                         input int exp_lat);
    int lat;
    bit got;
    n_stat = 0; n_data = 0; d_write = 1'b0;
    exp_wdata = wr ? {24'h0, b} : 32'h0;
    bus.cmd_valid = 1'b1; bus.cmd_write = wr; bus.cmd_wdata = b; bus.rsp_ready = 1'b0;
    chk({nm, ".cmd_ready_idle"}, 32'(bus.cmd_ready), 32'h1);
    @(posedge HCLK);
    lat = 0; got = 1'b0;
    while (lat < 300) begin
      @(negedge HCLK);
      if (lat == 0) begin
        bus.cmd_valid = 1'b0;
        chk({nm, ".cmd_ready_busy"}, 32'(bus.cmd_ready), 32'h0);
      end
      if (bus.rsp_valid === 1'b1) begin
        got = 1'b1;
        break;
      end
      @(posedge HCLK);
      lat++;
    end
    chk({nm, ".rsp_arrived"}, 32'(got), 32'h1);
    if (!got) return;
    chk({nm, ".latency"}, 32'(lat), 32'(exp_lat));
    chk({nm, ".rsp_err"}, 32'(bus.rsp_err), 32'(exp_err));
    if (!exp_err) chk({nm, ".rsp_rdata"}, 32'(bus.rsp_rdata), 32'(exp_rdata));
    chk({nm, ".polls"}, 32'(n_stat), 32'(exp_polls));
    chk({nm, ".data_xfers"}, 32'(n_data), exp_err ? 32'h0 : 32'h1);
    if (n_data > 0) chk({nm, ".data_hwrite"}, 32'(d_write), 32'(wr));
    for (int i = 0; i < hold; i++) begin
      if (b2b) begin bus.cmd_valid = 1'b1; bus.cmd_write = nwr; bus.cmd_wdata = nb; end
      @(posedge HCLK);
      @(negedge HCLK);
      chk({nm, ".hold_valid"}, 32'(bus.rsp_valid), 32'h1);
      chk({nm, ".hold_err"}, 32'(bus.rsp_err), 32'(exp_err));
      if (!exp_err) chk({nm, ".hold_rdata"}, 32'(bus.rsp_rdata), 32'(exp_rdata));
      chk({nm, ".hold_cmd_ready"}, 32'(bus.cmd_ready), 32'h0);
      chk({nm, ".hold_htrans"}, 32'(bus.HTRANS), 32'(HTRANS_IDLE));
    end
    if (b2b) begin bus.cmd_valid = 1'b1; bus.cmd_write = nwr; bus.cmd_wdata = nb; end
    bus.rsp_ready = 1'b1;
    @(posedge HCLK);
    @(negedge HCLK);
    bus.rsp_ready = 1'b0;
    chk({nm, ".post_valid"}, 32'(bus.rsp_valid), 32'h0);
    chk({nm, ".post_cmd_ready"}, 32'(bus.cmd_ready), 32'h1);
    chk({nm, ".post_hwdata"}, bus.HWDATA, 32'h0);
    chk({nm, ".post_htrans"}, 32'(bus.HTRANS), 32'(HTRANS_IDLE));
  endtask

  // Reference timing: each poll costs two edges, the data access two more, every stall one more
  function automatic int model_lat(input int polls, input bit ok, input int wt);
    return 2 * polls + (ok ? 2 : 0) + wt * (polls + (ok ? 1 : 0));
  endfunction

  typedef struct {
    logic        wr;
    logic [7:0]  b;
    logic [31:0] st [4];
    int          nst;
    logic [31:0] rd;
    int          wt;
    logic        exp_err;
    int          exp_polls;
    logic [7:0]  exp_rdata;
    int          exp_lat;
  } vec_t;

  vec_t vecs [10];

  initial begin : main
    int k, polls, hold, wt;
    logic wr, err;
    logic [7:0] b;
    logic [31:0] w, rd;

    vecs[0] = '{1'b1, 8'hA5, '{32'h0, 32'h0, 32'h0, 32'h0}, 1, 32'h0,         0, 1'b0, 1, 8'h00, 4};
    vecs[1] = '{1'b0, 8'h00, '{32'h1, 32'h1, 32'h0, 32'h0}, 3, 32'h0000_003C, 0, 1'b0, 3, 8'h3C, 8};
    vecs[2] = '{1'b1, 8'h5A, '{32'h2, 32'h0, 32'h0, 32'h0}, 1, 32'h0,         0, 1'b1, 4, 8'h00, 8};
    vecs[3] = '{1'b1, 8'hC3, '{32'h0, 32'h0, 32'h0, 32'h0}, 1, 32'h0,         3, 1'b0, 1, 8'h00, 10};
    vecs[4] = '{1'b0, 8'h00, '{32'h1, 32'h0, 32'h0, 32'h0}, 1, 32'h0000_0011, 0, 1'b1, 4, 8'h00, 8};
    vecs[5] = '{1'b1, 8'h3E, '{32'h1, 32'h0, 32'h0, 32'h0}, 1, 32'h0,         0, 1'b0, 1, 8'h00, 4};
    vecs[6] = '{1'b0, 8'h00, '{32'h2, 32'h0, 32'h0, 32'h0}, 1, 32'hFFFF_FF81, 0, 1'b0, 1, 8'h81, 4};
    vecs[7] = '{1'b1, 8'h00, '{32'h2, 32'h2, 32'h2, 32'h0}, 4, 32'h0,         0, 1'b0, 4, 8'h00, 10};
    vecs[8] = '{1'b0, 8'h00, '{32'h1, 32'h1, 32'h1, 32'h1}, 4, 32'h0000_00AA, 1, 1'b1, 4, 8'h00, 12};
    vecs[9] = '{1'b0, 8'h00, '{32'h3, 32'h0, 32'h0, 32'h0}, 2, 32'h0000_0055, 2, 1'b0, 2, 8'h55, 12};

    HRESET = 1'b1;
    bus.cmd_valid = 1'b0; bus.cmd_write = 1'b0; bus.cmd_wdata = 8'h00; bus.rsp_ready = 1'b0;
    rd_val = 32'h0; slv_wait = 0; exp_wdata = 32'h0;
    repeat (3) @(posedge HCLK);
    @(negedge HCLK);
    HRESET = 1'b0;
    chk("rst.htrans", 32'(bus.HTRANS), 32'(HTRANS_IDLE));
    chk("rst.haddr", bus.HADDR, 32'h0);
    chk("rst.hwrite", 32'(bus.HWRITE), 32'h0);
    chk("rst.hwdata", bus.HWDATA, 32'h0);
    chk("rst.rsp_valid", 32'(bus.rsp_valid), 32'h0);
    chk("rst.rsp_rdata", 32'(bus.rsp_rdata), 32'h0);
    chk("rst.rsp_err", 32'(bus.rsp_err), 32'h0);
    chk("rst.cmd_ready", 32'(bus.cmd_ready), 32'h1);

    for (int i = 0; i < 10; i++) begin
      stat_q.delete();
      for (int j = 0; j < vecs[i].nst; j++) stat_q.push_back(vecs[i].st[j]);
      rd_val = vecs[i].rd;
      slv_wait = vecs[i].wt;
      run_cmd($sformatf("vec%0d", i), vecs[i].wr, vecs[i].b, 0, 1'b0, 1'b0, 8'h00,
              vecs[i].exp_err, vecs[i].exp_polls, vecs[i].exp_rdata, vecs[i].exp_lat);
    end

    // Response held for 5 cycles while the next command is already offered
    stat_q.delete(); stat_q.push_back(32'h0); rd_val = 32'h0; slv_wait = 0;
    run_cmd("b2b_a", 1'b1, 8'h96, 5, 1'b1, 1'b0, 8'h00, 1'b0, 1, 8'h00, 4);
    stat_q.delete(); stat_q.push_back(32'h0); rd_val = 32'h0000_00E7;
    run_cmd("b2b_b", 1'b0, 8'h00, 0, 1'b0, 1'b0, 8'h00, 1'b0, 1, 8'hE7, 4);

    // Reset during the write data phase, then the poll count must start over
    stat_q.delete(); stat_q.push_back(32'h2); stat_q.push_back(32'h0); slv_wait = 3;
    exp_wdata = 32'h0000_0077;
    bus.cmd_valid = 1'b1; bus.cmd_write = 1'b1; bus.cmd_wdata = 8'h77;
    @(posedge HCLK);
    @(negedge HCLK);
    bus.cmd_valid = 1'b0;
    k = 0;
    while (!(bus.HTRANS === HTRANS_NONSEQ && bus.HADDR === BASE) && k < 100) begin
      @(posedge HCLK);
      @(negedge HCLK);
      k++;
    end
    chk("rstx.reach_xaddr", 32'(k < 100), 32'h1);
    @(posedge HCLK);
    @(negedge HCLK);
    chk("rstx.hwdata_xdata", bus.HWDATA, 32'h0000_0077);
    HRESET = 1'b1;
    @(posedge HCLK);
    @(negedge HCLK);
    HRESET = 1'b0;
    chk("rstx.htrans", 32'(bus.HTRANS), 32'(HTRANS_IDLE));
    chk("rstx.rsp_valid", 32'(bus.rsp_valid), 32'h0);
    chk("rstx.cmd_ready", 32'(bus.cmd_ready), 32'h1);
    chk("rstx.hwdata", bus.HWDATA, 32'h0);
    chk("rstx.haddr", bus.HADDR, 32'h0);
    stat_q.delete(); stat_q.push_back(32'h2); slv_wait = 0;
    run_cmd("rstx_stuck", 1'b1, 8'h12, 0, 1'b0, 1'b0, 8'h00, 1'b1, 4, 8'h00, 8);
    stat_q.delete(); stat_q.push_back(32'h0);
    run_cmd("rstx_write", 1'b1, 8'h34, 0, 1'b0, 1'b0, 8'h00, 1'b0, 1, 8'h00, 4);

    // Random commands against the timing/response model
    for (int n = 0; n < 30; n++) begin
      wr = 1'($urandom_range(0, 1));
      b = 8'($urandom);
      rd = $urandom;
      k = int'($urandom_range(0, 5));
      wt = int'($urandom_range(0, 2));
      hold = int'($urandom_range(0, 2));
      stat_q.delete();
      for (int j = 0; j < k; j++) begin
        w = $urandom;
        if (wr) w[TXFULL_BIT] = 1'b1; else w[RXEMPTY_BIT] = 1'b1;
        stat_q.push_back(w);
      end
      w = $urandom;
      if (wr) w[TXFULL_BIT] = 1'b0; else w[RXEMPTY_BIT] = 1'b0;
      stat_q.push_back(w);
      err = (k >= int'(PMAX));
      polls = err ? int'(PMAX) : k + 1;
      rd_val = rd;
      slv_wait = wt;
      run_cmd($sformatf("rnd%0d", n), wr, b, hold, 1'b0, 1'b0, 8'h00, err, polls,
              wr ? 8'h00 : rd[7:0], model_lat(polls, !err, wt));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
